// File: rtl/conv_stream_ctrl.sv
// conv_stream_ctrl: stream wrapper around the 3x3 Gaussian convolution core.
// Feeds AXI-Stream input beats into the core, appends one row of zero flush
// beats at end of frame, and discards the core's first row of outputs. It also
// regenerates output framing (tuser on first beat, tlast on last beat).
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_IDLE  | core held in reset, waiting for s_tvalid to start a frame
// ST_RUN   | accepting input beats, one core advance per accepted beat
// ST_FLUSH | issuing one row of zero beats to push out the last row
// ST_DRAIN | waiting for the final output beat to handshake
module conv_stream_ctrl #(
  parameter int PIXELS_PER_BEAT = 16,
  parameter int IMAGE_DIM       = 512,
  parameter int DATA_WIDTH      = 8 * PIXELS_PER_BEAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  input  logic                  s_tlast,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast,
  output logic                  m_tuser,
  output logic                  core_stall,
  output logic                  core_aresetn,
  output logic [DATA_WIDTH-1:0] core_inp_frame,
  input  logic [DATA_WIDTH-1:0] core_out_frame,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  err_tlast
);

  localparam int BEATS_PER_ROW = IMAGE_DIM / PIXELS_PER_BEAT;
  localparam int TOTAL         = BEATS_PER_ROW * IMAGE_DIM;
  localparam int CNT_W         = $clog2(TOTAL + BEATS_PER_ROW + 1);

  localparam logic [CNT_W-1:0] ROW_BEATS = CNT_W'(BEATS_PER_ROW);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] LAST_ADV  = CNT_W'(TOTAL + BEATS_PER_ROW - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
  logic [CNT_W-1:0] adv_cnt_q, adv_cnt_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             out_pend_q, out_pend_d;
  logic             err_tlast_q, err_tlast_d;

  logic can_adv;
  logic adv;
  logic accept;
  logic out_hs;
  logic last_out;

  // Advance qualification: the core may only step when its held result is
  // free or leaving this cycle, so s_tready follows m_tready combinationally.
  always_comb begin
    can_adv  = !out_pend_q || m_tready;
    adv      = 1'b0;
    case (state_q)
      ST_RUN:   adv = s_tvalid && can_adv;
      ST_FLUSH: adv = can_adv;
      default:  adv = 1'b0;
    endcase
    accept   = (state_q == ST_RUN) && adv;
    out_hs   = out_pend_q && m_tready;
    last_out = (out_cnt_q == LAST_BEAT);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; frame length is set purely by the counters.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (s_tvalid) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (accept && (in_cnt_q == LAST_BEAT)) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (adv && (adv_cnt_q == LAST_ADV)) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (out_hs && last_out) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Moore/Mealy outputs toward the input stream and the core.
  always_comb begin
    s_tready       = (state_q == ST_RUN) && can_adv;
    core_stall     = !adv;
    core_aresetn   = (state_q != ST_IDLE);
    core_inp_frame = (state_q == ST_RUN) ? s_tdata : '0;
    busy           = (state_q != ST_IDLE);
    frame_done     = (state_q == ST_DRAIN) && out_hs && last_out;
  end

  // Output stream: the core holds its output while stalled, so data is a
  // straight pass-through and only framing is derived from out_cnt.
  always_comb begin
    m_tvalid  = out_pend_q;
    m_tdata   = core_out_frame;
    m_tuser   = (out_cnt_q == '0);
    m_tlast   = last_out;
    err_tlast = err_tlast_q;
  end

  // Counter, pending-result and framing-error next values.
  always_comb begin
    in_cnt_d    = in_cnt_q;
    adv_cnt_d   = adv_cnt_q;
    out_cnt_d   = out_cnt_q;
    out_pend_d  = out_pend_q;
    err_tlast_d = err_tlast_q;
    if (state_q == ST_IDLE) begin
      in_cnt_d   = '0;
      adv_cnt_d  = '0;
      out_cnt_d  = '0;
      out_pend_d = 1'b0;
      if (s_tvalid) err_tlast_d = 1'b0;
    end else begin
      if (accept) in_cnt_d = in_cnt_q + CNT_ONE;
      if (adv)    adv_cnt_d = adv_cnt_q + CNT_ONE;
      if (out_hs) out_cnt_d = out_cnt_q + CNT_ONE;
      // The first row of advances only primes the core's line buffer.
      if (adv && (adv_cnt_q >= ROW_BEATS)) begin
        out_pend_d = 1'b1;
      end else if (out_hs) begin
        out_pend_d = 1'b0;
      end
      if (accept && (s_tlast != (in_cnt_q == LAST_BEAT))) err_tlast_d = 1'b1;
      // Leave DRAIN with counters already cleared so IDLE shows out_cnt==0.
      if (state_d == ST_IDLE) begin
        in_cnt_d  = '0;
        adv_cnt_d = '0;
        out_cnt_d = '0;
      end
    end
  end

  // Counter and flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      in_cnt_q    <= '0;
      adv_cnt_q   <= '0;
      out_cnt_q   <= '0;
      out_pend_q  <= 1'b0;
      err_tlast_q <= 1'b0;
    end else begin
      in_cnt_q    <= in_cnt_d;
      adv_cnt_q   <= adv_cnt_d;
      out_cnt_q   <= out_cnt_d;
      out_pend_q  <= out_pend_d;
      err_tlast_q <= err_tlast_d;
    end
  end

endmodule
